// File: rtl/backprop_layer_scheduler_pkg.sv
// Shared definitions for the backprop blocks: scheduler state encoding and a
// ceiling-log2 helper used to size counters.
package backprop_layer_scheduler_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } bls_state_e;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/backprop_layer_scheduler_watchdog_counter.sv
// Wait-cycle watchdog for the backprop scheduler. Counts enabled cycles from
// zero and flags expiry once the count sits at TIMEOUT-1.
module watchdog_counter
    import backprop_layer_scheduler_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (clog2(TIMEOUT) < 1) ? 1 : clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count;

    // Clear wins over enable; the count parks at its last value so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != LAST_COUNT)) begin
            count <= count + CW'(1);
        end
    end

    assign expired = (count == LAST_COUNT);

endmodule

// File: rtl/backprop_layer_scheduler.sv
// Backward-pass layer scheduler: walks layers LAYER_NUM-1 down to 1, kicks the
// error propagator for each, waits (with a watchdog) for its delta and writes
// it into the delta store. Every output is a flop.
module backprop_layer_scheduler
    import backprop_layer_scheduler_pkg::*;
#(
    parameter int LAYER_NUM        = 4,
    parameter int LAYER_ADDR_WIDTH = 2,
    parameter int DELTA_WIDTH      = 64,
    parameter int TIMEOUT          = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        abort,
    output logic                        busy,
    output logic                        done,
    output logic                        error,
    output logic [LAYER_ADDR_WIDTH-1:0] layer,
    output logic                        prop_start,
    input  logic                        prop_valid,
    input  logic [DELTA_WIDTH-1:0]      prop_delta,
    output logic                        wr_en,
    output logic [LAYER_ADDR_WIDTH-1:0] wr_addr,
    output logic [DELTA_WIDTH-1:0]      wr_data
);

    localparam logic [LAYER_ADDR_WIDTH-1:0] TOP_LAYER  = LAYER_ADDR_WIDTH'(LAYER_NUM - 1);
    localparam logic [LAYER_ADDR_WIDTH-1:0] LAST_LAYER = LAYER_ADDR_WIDTH'(1);

    bls_state_e state;
    bls_state_e next_state;

    logic                        busy_nxt;
    logic                        done_nxt;
    logic                        error_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] layer_nxt;
    logic                        prop_start_nxt;
    logic                        wr_en_nxt;
    logic [LAYER_ADDR_WIDTH-1:0] wr_addr_nxt;
    logic [DELTA_WIDTH-1:0]      wr_data_nxt;

    logic wd_clear;
    logic wd_enable;
    logic wd_expired;

    // The watchdog only runs while waiting on a missing result; any other state rearms it.
    assign wd_clear  = (state != WAIT);
    assign wd_enable = (state == WAIT) && !prop_valid;

    watchdog_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (wd_clear),
        .enable  (wd_enable),
        .expired (wd_expired)
    );

    // State and registered outputs, all forced to zero while reset is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            layer      <= '0;
            prop_start <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            state      <= next_state;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
            layer      <= layer_nxt;
            prop_start <= prop_start_nxt;
            wr_en      <= wr_en_nxt;
            wr_addr    <= wr_addr_nxt;
            wr_data    <= wr_data_nxt;
        end
    end

    // Next state: abort beats everything, and a valid result beats a same-cycle timeout.
    always_comb begin
        next_state = state;
        if (abort && (state != IDLE)) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) next_state = ISSUE;
                ISSUE:   next_state = WAIT;
                WAIT: begin
                    if (prop_valid) begin
                        next_state = WRITE;
                    end else if (wd_expired) begin
                        next_state = IDLE;
                    end
                end
                WRITE:   next_state = (layer == LAST_LAYER) ? DONE : ISSUE;
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    // Next output values, computed alongside the transition so each output lines up with its state.
    always_comb begin
        busy_nxt       = busy;
        done_nxt       = 1'b0;
        error_nxt      = error;
        layer_nxt      = layer;
        prop_start_nxt = 1'b0;
        wr_en_nxt      = 1'b0;
        wr_addr_nxt    = wr_addr;
        wr_data_nxt    = wr_data;
        if (abort && (state != IDLE)) begin
            busy_nxt = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        error_nxt      = 1'b0;
                        layer_nxt      = TOP_LAYER;
                        busy_nxt       = 1'b1;
                        prop_start_nxt = 1'b1;
                    end
                end
                ISSUE: begin
                end
                WAIT: begin
                    if (prop_valid) begin
                        wr_data_nxt = prop_delta;
                        wr_addr_nxt = layer;
                        wr_en_nxt   = 1'b1;
                    end else if (wd_expired) begin
                        error_nxt = 1'b1;
                        busy_nxt  = 1'b0;
                    end
                end
                WRITE: begin
                    if (layer == LAST_LAYER) begin
                        done_nxt = 1'b1;
                    end else begin
                        layer_nxt      = layer - LAYER_ADDR_WIDTH'(1);
                        prop_start_nxt = 1'b1;
                    end
                end
                DONE: begin
                    busy_nxt = 1'b0;
                end
                default: begin
                    busy_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_backprop_layer_scheduler.sv
// Self-checking bench for backprop_layer_scheduler: a table of latency/delta
// passes, randomized passes against a cycle-level reference model, and
// hand-written abort, stale-error, mid-pass reset and two-layer sequences.
module tb_backprop_layer_scheduler;

    localparam int TIMEOUT = 16;
    localparam int AW      = 2;
    localparam int DW      = 64;

    typedef int          lat3_t[3];
    typedef logic [63:0] d3_t[3];

    typedef struct {
        int          lat0;
        int          lat1;
        int          lat2;
        logic [63:0] d0;
        logic [63:0] d1;
        logic [63:0] d2;
        int          expWrites;
        logic        expError;
        int          expDone;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          error;
    logic [AW-1:0] layer;
    logic          prop_start;
    logic          prop_valid;
    logic [DW-1:0] prop_delta;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;

    logic          start2;
    logic          abort2;
    logic          busy2;
    logic          done2;
    logic          error2;
    logic [0:0]    layer2;
    logic          prop_start2;
    logic          prop_valid2;
    logic [DW-1:0] prop_delta2;
    logic          wr_en2;
    logic [0:0]    wr_addr2;
    logic [DW-1:0] wr_data2;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    backprop_layer_scheduler #(
        .LAYER_NUM (4), .LAYER_ADDR_WIDTH (AW), .DELTA_WIDTH (DW), .TIMEOUT (TIMEOUT)
    ) dut (
        .clk (clk), .rst (rst), .start (start), .abort (abort),
        .busy (busy), .done (done), .error (error), .layer (layer),
        .prop_start (prop_start), .prop_valid (prop_valid), .prop_delta (prop_delta),
        .wr_en (wr_en), .wr_addr (wr_addr), .wr_data (wr_data)
    );

    backprop_layer_scheduler #(
        .LAYER_NUM (2), .LAYER_ADDR_WIDTH (1), .DELTA_WIDTH (DW), .TIMEOUT (TIMEOUT)
    ) dut2 (
        .clk (clk), .rst (rst), .start (start2), .abort (abort2),
        .busy (busy2), .done (done2), .error (error2), .layer (layer2),
        .prop_start (prop_start2), .prop_valid (prop_valid2), .prop_delta (prop_delta2),
        .wr_en (wr_en2), .wr_addr (wr_addr2), .wr_data (wr_data2)
    );

    // Free-running clock and a cycle index advanced on each rising edge.
    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    // Propagator model: answers layer i of a pass passLat[i] cycles after its prop_start; 0 means never.
    lat3_t passLat = '{0, 0, 0};
    d3_t   passDelta = '{64'h0, 64'h0, 64'h0};
    int    layerIdx = 0;
    int    pendLayer = 0;
    int    pendCnt = 0;
    bit    pendActive = 1'b0;
    int    newLat;
    always @(negedge clk) begin
        prop_valid = 1'b0;
        prop_delta = {$urandom, $urandom};
        if (!rst) begin
            pendActive = 1'b0;
            layerIdx   = 0;
        end else begin
            if (pendActive) begin
                pendCnt = pendCnt - 1;
                if (pendCnt == 0) begin
                    prop_valid = 1'b1;
                    prop_delta = passDelta[pendLayer];
                    pendActive = 1'b0;
                end
            end
            if (!busy) layerIdx = 0;
            if (prop_start && (layerIdx < 3)) begin
                newLat = passLat[layerIdx];
                if (newLat > 0) begin
                    pendCnt    = newLat;
                    pendLayer  = layerIdx;
                    pendActive = 1'b1;
                end
                layerIdx = layerIdx + 1;
            end
        end
    end

    // Event log of the four-layer instance, sampled mid-cycle.
    int            psCycQ[$];
    int            wrCycQ[$];
    logic [AW-1:0] wrAddrQ[$];
    logic [DW-1:0] wrDataQ[$];
    int            doneCycQ[$];
    int            errRiseCyc = -1;
    logic          errPrev = 1'b0;
    always @(negedge clk) begin
        if (prop_start) psCycQ.push_back(cyc);
        if (wr_en) begin
            wrCycQ.push_back(cyc);
            wrAddrQ.push_back(wr_addr);
            wrDataQ.push_back(wr_data);
        end
        if (done) doneCycQ.push_back(cyc);
        if (error && !errPrev) errRiseCyc = cyc;
        errPrev = error;
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        tests = tests + 1;
        if (actual !== expected) begin
            fails = fails + 1;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Runs one full pass with the given per-layer latencies and deltas; returns the start-sampling cycle.
    task automatic applyStimulus(input lat3_t lat, input d3_t d, output int startCyc);
        int n;
        passLat   = lat;
        passDelta = d;
        @(negedge clk);
        start    = 1'b1;
        startCyc = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (busy && (n < 400)) begin
            @(negedge clk);
            n = n + 1;
        end
        checkOutput("pass_finished", {63'd0, busy}, 64'd0);
        repeat (3) @(negedge clk);
    endtask

    // Reference model: layer i is attempted at prop_start cycle ps_i, writes at ps_i+lat_i+1, next layer
    // starts at ps_i+lat_i+2; a latency beyond TIMEOUT ends the pass with error at ps_i+TIMEOUT+1.
    task automatic verifyPass(input string tag, input lat3_t lat, input d3_t d, input int startCyc,
                              input int psBase, input int wrBase, input int doneBase);
        int psExp;
        int attempted;
        int written;
        bit expErr;
        int errCycExp;
        int lastWr;
        psExp     = startCyc;
        attempted = 0;
        written   = 0;
        expErr    = 1'b0;
        errCycExp = 0;
        lastWr    = 0;
        for (int i = 0; i < 3; i++) begin
            attempted = attempted + 1;
            if (psBase + i < psCycQ.size())
                checkOutput({tag, "_ps_cycle"}, 64'(psCycQ[psBase + i]), 64'(psExp));
            if (lat[i] > TIMEOUT) begin
                expErr    = 1'b1;
                errCycExp = psExp + TIMEOUT + 1;
                break;
            end
            if (wrBase + written < wrCycQ.size()) begin
                checkOutput({tag, "_wr_addr"}, 64'(wrAddrQ[wrBase + written]), 64'(3 - i));
                checkOutput({tag, "_wr_data"}, wrDataQ[wrBase + written], d[i]);
                checkOutput({tag, "_wr_cycle"}, 64'(wrCycQ[wrBase + written]), 64'(psExp + lat[i] + 1));
            end
            lastWr  = psExp + lat[i] + 1;
            written = written + 1;
            psExp   = psExp + lat[i] + 2;
        end
        checkOutput({tag, "_ps_count"}, 64'(psCycQ.size() - psBase), 64'(attempted));
        checkOutput({tag, "_wr_count"}, 64'(wrCycQ.size() - wrBase), 64'(written));
        checkOutput({tag, "_done_count"}, 64'(doneCycQ.size() - doneBase), 64'(expErr ? 0 : 1));
        if (!expErr && (doneCycQ.size() > doneBase))
            checkOutput({tag, "_done_cycle"}, 64'(doneCycQ[doneBase]), 64'(lastWr + 1));
        checkOutput({tag, "_error"}, {63'd0, error}, {63'd0, expErr});
        if (expErr)
            checkOutput({tag, "_error_cycle"}, 64'(errRiseCyc), 64'(errCycExp));
    endtask

    vec_t  vecs[7];
    lat3_t lat;
    d3_t   dl;
    int    sCyc;
    int    psB;
    int    wrB;
    int    dnB;

    initial begin
        vecs[0] = '{5, 5, 5, 64'h11, 64'h22, 64'h33, 3, 1'b0, 1};
        vecs[1] = '{1, 1, 1, 64'h0123456789abcdef, 64'hfedcba9876543210, 64'h5a5a5a5aa5a5a5a5, 3, 1'b0, 1};
        vecs[2] = '{16, 16, 16, 64'haaaa, 64'hbbbb, 64'hcccc, 3, 1'b0, 1};
        vecs[3] = '{17, 1, 1, 64'h1, 64'h2, 64'h3, 0, 1'b1, 0};
        vecs[4] = '{2, 17, 1, 64'h44, 64'h55, 64'h66, 1, 1'b1, 0};
        vecs[5] = '{3, 9, 16, 64'hdead, 64'hbeef, 64'hcafe, 3, 1'b0, 1};
        vecs[6] = '{1, 4, 17, 64'h77, 64'h88, 64'h99, 2, 1'b1, 0};

        rst = 1'b0; start = 1'b0; abort = 1'b0;
        start2 = 1'b0; abort2 = 1'b0; prop_valid2 = 1'b0; prop_delta2 = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_ctrl", 64'({busy, done, error, prop_start, wr_en, layer, wr_addr}), 64'd0);
        checkOutput("reset_wr_data", wr_data, 64'd0);
        checkOutput("reset_ctrl_l2", 64'({busy2, done2, error2, prop_start2, wr_en2, layer2, wr_addr2}), 64'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven passes.
        for (int v = 0; v < 7; v++) begin
            lat = '{vecs[v].lat0, vecs[v].lat1, vecs[v].lat2};
            dl  = '{vecs[v].d0, vecs[v].d1, vecs[v].d2};
            psB = psCycQ.size(); wrB = wrCycQ.size(); dnB = doneCycQ.size();
            applyStimulus(lat, dl, sCyc);
            checkOutput($sformatf("vec%0d_writes", v), 64'(wrCycQ.size() - wrB), 64'(vecs[v].expWrites));
            checkOutput($sformatf("vec%0d_error", v), {63'd0, error}, {63'd0, vecs[v].expError});
            checkOutput($sformatf("vec%0d_done", v), 64'(doneCycQ.size() - dnB), 64'(vecs[v].expDone));
            verifyPass($sformatf("vec%0d", v), lat, dl, sCyc, psB, wrB, dnB);
        end

        // Randomized passes against the reference model.
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < 3; i++) begin
                lat[i] = int'($urandom_range(1, 18));
                dl[i]  = {$urandom, $urandom};
            end
            psB = psCycQ.size(); wrB = wrCycQ.size(); dnB = doneCycQ.size();
            applyStimulus(lat, dl, sCyc);
            verifyPass($sformatf("rand%0d", r), lat, dl, sCyc, psB, wrB, dnB);
        end

        // Second start during WAIT is ignored, then abort returns to IDLE without writing.
        passLat = '{0, 0, 0};
        psB = psCycQ.size(); wrB = wrCycQ.size(); dnB = doneCycQ.size();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("abort_layer_hold", 64'(layer), 64'd3);
        checkOutput("abort_busy_wait", {63'd0, busy}, 64'd1);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        checkOutput("restart_ignored", 64'(psCycQ.size() - psB), 64'd1);
        checkOutput("restart_layer", 64'(layer), 64'd3);
        abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("abort_error", {63'd0, error}, 64'd0);
        repeat (5) @(negedge clk);
        checkOutput("abort_no_write", 64'(wrCycQ.size() - wrB), 64'd0);
        checkOutput("abort_no_done", 64'(doneCycQ.size() - dnB), 64'd0);
        checkOutput("abort_no_reissue", 64'(psCycQ.size() - psB), 64'd1);

        // A timeout leaves error set; the next start clears it and abort keeps it clear.
        lat = '{17, 0, 0};
        dl  = '{64'h1, 64'h2, 64'h3};
        applyStimulus(lat, dl, sCyc);
        checkOutput("stale_error_set", {63'd0, error}, 64'd1);
        passLat = '{0, 0, 0};
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        checkOutput("stale_error_cleared", {63'd0, error}, 64'd0);
        checkOutput("stale_busy", {63'd0, busy}, 64'd1);
        @(negedge clk); abort = 1'b1;
        @(negedge clk); abort = 1'b0;
        checkOutput("stale_abort_busy", {63'd0, busy}, 64'd0);
        checkOutput("stale_abort_error", {63'd0, error}, 64'd0);

        // Reset asserted mid-WAIT clears every output at once and nothing resumes afterwards.
        repeat (2) @(negedge clk);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rst_mid_ctrl", 64'({busy, done, error, prop_start, wr_en, layer, wr_addr}), 64'd0);
        checkOutput("rst_mid_wr_data", wr_data, 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        psB = psCycQ.size(); wrB = wrCycQ.size();
        repeat (10) @(negedge clk);
        checkOutput("rst_release_idle", {63'd0, busy}, 64'd0);
        checkOutput("rst_release_no_issue", 64'(psCycQ.size() - psB), 64'd0);
        checkOutput("rst_release_no_write", 64'(wrCycQ.size() - wrB), 64'd0);

        // Two-layer instance: one iteration writing address 1, then done.
        @(negedge clk); start2 = 1'b1;
        @(negedge clk); start2 = 1'b0;
        checkOutput("l2_prop_start", {63'd0, prop_start2}, 64'd1);
        checkOutput("l2_layer", 64'(layer2), 64'd1);
        checkOutput("l2_busy", {63'd0, busy2}, 64'd1);
        @(negedge clk);
        prop_valid2 = 1'b1; prop_delta2 = 64'hc0ffee0012345678;
        @(negedge clk);
        prop_valid2 = 1'b0; prop_delta2 = '0;
        checkOutput("l2_wr_en", {63'd0, wr_en2}, 64'd1);
        checkOutput("l2_wr_addr", 64'(wr_addr2), 64'd1);
        checkOutput("l2_wr_data", wr_data2, 64'hc0ffee0012345678);
        @(negedge clk);
        checkOutput("l2_done", {63'd0, done2}, 64'd1);
        checkOutput("l2_no_reissue", {63'd0, prop_start2}, 64'd0);
        @(negedge clk);
        checkOutput("l2_done_pulse", {63'd0, done2}, 64'd0);
        checkOutput("l2_idle", {63'd0, busy2}, 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Hard stop in case a sequence never returns.
    initial begin
        #500000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got hang, expected completion");
        $fatal(1, "[TB] aborted");
    end

endmodule
